// File: rtl/lcd1602_writer.sv
// HD44780/LCD1602 8-bit parallel writer: power-on init, then repeated two-line frames from snapshots.
// Optional LCD1602_WRITE_ON_CHANGE_EN: skip frames whose snapshot matches the last one shown.
module lcd1602_writer #(
  parameter int unsigned PHASE_CYC = 4,
  parameter int unsigned CLR_WAIT  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] line_rom1,
  input  logic [127:0] line_rom2,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_en,
  output logic [7:0]   lcd_data,
  output logic         frame_done
);

  localparam int unsigned CNT_MAX = (PHASE_CYC > CLR_WAIT) ? PHASE_CYC : CLR_WAIT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_INIT, S_WAIT_CLR, S_SNAP, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2, S_DONE
  } state_e;

  typedef enum logic [1:0] {P_SETUP, P_STROBE, P_HOLD} phase_e;

  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         idx_q, idx_d;
  logic [127:0]       line1_q, line1_d, line2_q, line2_d;
  logic               rs_q, rs_d, en_q, en_d, fd_q, fd_d;
  logic [7:0]         data_q, data_d;
  logic               byte_end;
`ifdef LCD1602_WRITE_ON_CHANGE_EN
  logic               seen_q, seen_d;
`endif

  function automatic logic is_byte_state(input state_e s);
    return (s == S_INIT) || (s == S_ADDR1) || (s == S_LINE1) ||
           (s == S_ADDR2) || (s == S_LINE2);
  endfunction

  // State register and registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      phase_q <= P_SETUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      line1_q <= '0;
      line2_q <= '0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= 8'h00;
      fd_q    <= 1'b0;
`ifdef LCD1602_WRITE_ON_CHANGE_EN
      seen_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      line1_q <= line1_d;
      line2_q <= line2_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      data_q  <= data_d;
      fd_q    <= fd_d;
`ifdef LCD1602_WRITE_ON_CHANGE_EN
      seen_q  <= seen_d;
`endif
    end
  end

  // Next state; outputs are derived from the next state so they line up with state_q
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    line1_d  = line1_q;
    line2_d  = line2_q;
    byte_end = 1'b0;
`ifdef LCD1602_WRITE_ON_CHANGE_EN
    seen_d   = seen_q;
`endif

    if (is_byte_state(state_q)) begin
      if (cnt_q == CNT_W'(PHASE_CYC - 1)) begin
        cnt_d = '0;
        case (phase_q)
          P_SETUP:  phase_d = P_STROBE;
          P_STROBE: phase_d = P_HOLD;
          default: begin
            phase_d  = P_SETUP;
            byte_end = 1'b1;
          end
        endcase
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      S_INIT: if (byte_end) begin
        if (idx_q == 4'd3) begin
          idx_d   = '0;
          state_d = (CLR_WAIT == 0) ? S_SNAP : S_WAIT_CLR;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_WAIT_CLR: begin
        if (cnt_q == CNT_W'(CLR_WAIT - 1)) begin
          cnt_d   = '0;
          state_d = S_SNAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SNAP: begin
        line1_d = line_rom1;
        line2_d = line_rom2;
`ifdef LCD1602_WRITE_ON_CHANGE_EN
        if (!(seen_q && (line_rom1 == line1_q) && (line_rom2 == line2_q))) begin
          state_d = S_ADDR1;
        end
`else
        state_d = S_ADDR1;
`endif
      end
      S_ADDR1: if (byte_end) state_d = S_LINE1;
      S_LINE1: if (byte_end) begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = S_ADDR2;
      end
      S_ADDR2: if (byte_end) state_d = S_LINE2;
      S_LINE2: if (byte_end) begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = S_DONE;
      end
      default: begin
        state_d = S_SNAP;
`ifdef LCD1602_WRITE_ON_CHANGE_EN
        seen_d  = 1'b1;
`endif
      end
    endcase

    rs_d   = rs_q;
    data_d = data_q;
    en_d   = is_byte_state(state_d) && (phase_d == P_STROBE);
    fd_d   = (state_d == S_DONE);
    case (state_d)
      S_INIT: begin
        rs_d = 1'b0;
        case (idx_d)
          4'd0:    data_d = 8'h38;
          4'd1:    data_d = 8'h0C;
          4'd2:    data_d = 8'h06;
          default: data_d = 8'h01;
        endcase
      end
      S_ADDR1: begin rs_d = 1'b0; data_d = 8'h80; end
      S_LINE1: begin rs_d = 1'b1; data_d = line1_q[{~idx_d, 3'b000} +: 8]; end
      S_ADDR2: begin rs_d = 1'b0; data_d = 8'hC0; end
      S_LINE2: begin rs_d = 1'b1; data_d = line2_q[{~idx_d, 3'b000} +: 8]; end
      default: ;
    endcase
  end

  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_en     = en_q;
  assign lcd_data   = data_q;
  assign frame_done = fd_q;

endmodule
